// File: rtl/aline_acq_sequencer_if.sv
// Sweep/sample inputs, buffer write strobes and line-handoff handshake of the A-line sequencer.
// With OVERRUN_COUNT_EN defined the bundle also carries the 16-bit dropped-line counter.
interface aline_acq_sequencer_if;
  logic        enable;
  logic        sweep_trig;
  logic        sample_valid;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic        wr_bank;
  logic        line_valid;
  logic        line_bank;
  logic [9:0]  line_num;
  logic        line_ack;
  logic        frame_done;
  logic        overrun;
  logic        overrun_clr;
`ifdef OVERRUN_COUNT_EN
  logic [15:0] overrun_cnt;

  modport master (
    input  enable, sweep_trig, sample_valid, line_ack, overrun_clr,
    output wr_en, wr_addr, wr_bank, line_valid, line_bank, line_num,
           frame_done, overrun, overrun_cnt
  );
  modport slave (
    output enable, sweep_trig, sample_valid, line_ack, overrun_clr,
    input  wr_en, wr_addr, wr_bank, line_valid, line_bank, line_num,
           frame_done, overrun, overrun_cnt
  );
`else
  modport master (
    input  enable, sweep_trig, sample_valid, line_ack, overrun_clr,
    output wr_en, wr_addr, wr_bank, line_valid, line_bank, line_num,
           frame_done, overrun
  );
  modport slave (
    output enable, sweep_trig, sample_valid, line_ack, overrun_clr,
    input  wr_en, wr_addr, wr_bank, line_valid, line_bank, line_num,
           frame_done, overrun
  );
`endif
endinterface

// File: rtl/aline_acq_sequencer.sv
// A-line acquisition sequencer: ping-pong buffer writes one cycle after sample_valid, line handoff two cycles after the last sample.
// A line completing while readout still holds the previous one is dropped; OVERRUN_COUNT_EN adds a saturating drop counter.
module aline_acq_sequencer #(
  parameter int NSAMPLES = 1170,
  parameter int NLINES   = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  aline_acq_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARM, ACQ, DONE} state_t;

  localparam logic [10:0] LAST_SAMPLE = 11'(NSAMPLES - 1);
  localparam logic [9:0]  LAST_LINE   = 10'(NLINES - 1);

  state_t      state_q;
  logic        trig_q;
  logic [10:0] cnt_q;
  logic [9:0]  idx_q;
  logic        wr_en_q;
  logic [10:0] wr_addr_q;
  logic        wr_bank_q;
  logic        line_valid_q;
  logic        line_bank_q;
  logic [9:0]  line_num_q;
  logic        frame_done_q;
  logic        overrun_q;
  logic        overrun_d;

  logic trig_edge;
  logic still_pending;
  logic drop;

  assign trig_edge     = bus.sweep_trig & ~trig_q;
  // An ack in the completion cycle frees the slot before the new line claims it.
  assign still_pending = line_valid_q & ~bus.line_ack;
  assign drop          = (state_q == DONE) & bus.enable & still_pending;

  always_comb begin
    overrun_d = overrun_q;
    if (bus.overrun_clr) overrun_d = 1'b0;
    if (drop)            overrun_d = 1'b1;
  end

`ifdef OVERRUN_COUNT_EN
  logic [15:0] overrun_cnt_q;
  logic [15:0] overrun_cnt_d;

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (bus.overrun_clr)
      overrun_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && overrun_cnt_q != 16'hFFFF)
      overrun_cnt_d = overrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overrun_cnt_q <= '0;
    else          overrun_cnt_q <= overrun_cnt_d;
  end

  assign bus.overrun_cnt = overrun_cnt_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      line_valid_q <= 1'b0;
      line_bank_q  <= 1'b0;
      line_num_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      trig_q       <= bus.sweep_trig;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= overrun_d;
      if (bus.line_ack) line_valid_q <= 1'b0;
      if (state_q == IDLE) idx_q <= '0;

      if (!bus.enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (trig_edge) begin
              cnt_q   <= '0;
              state_q <= ACQ;
            end
          end
          ACQ: begin
            if (bus.sample_valid) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q;
              cnt_q     <= cnt_q + 11'd1;
              if (cnt_q == LAST_SAMPLE) state_q <= DONE;
            end
          end
          DONE: begin
            // On a drop the bank is not flipped, so the next sweep overwrites it.
            if (!still_pending) begin
              line_valid_q <= 1'b1;
              line_bank_q  <= wr_bank_q;
              line_num_q   <= idx_q;
              wr_bank_q    <= ~wr_bank_q;
            end
            frame_done_q <= (idx_q == LAST_LINE);
            idx_q        <= (idx_q == LAST_LINE) ? 10'd0 : idx_q + 10'd1;
            state_q      <= ARM;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.line_valid = line_valid_q;
  assign bus.line_bank  = line_bank_q;
  assign bus.line_num   = line_num_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_aline_acq_sequencer.sv
// Directed and randomized sweeps against a line-level model of buffer handoff, drops and frame indexing.
module tb_aline_acq_sequencer;
  localparam int NS = 4;
  localparam int NL = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Line-level model state
  bit m_pend;
  bit m_lbank;
  bit m_bank;
  bit m_ovr;
  bit m_fd;
  int m_lnum;
  int m_idx;
  int m_cnt;

  aline_acq_sequencer_if bus ();

  aline_acq_sequencer #(.NSAMPLES(NS), .NLINES(NL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_lbank = 0; m_bank = 0; m_ovr = 0; m_fd = 0;
    m_lnum = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_wr_en"}, bus.wr_en, 1'b0);
    chkv({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk1({tag, "_wr_bank"}, bus.wr_bank, 1'b0);
    chk1({tag, "_line_valid"}, bus.line_valid, 1'b0);
    chk1({tag, "_line_bank"}, bus.line_bank, 1'b0);
    chkv({tag, "_line_num"}, 32'(bus.line_num), 0);
    chk1({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk1({tag, "_overrun"}, bus.overrun, 1'b0);
`ifdef OVERRUN_COUNT_EN
    chkv({tag, "_overrun_cnt"}, 32'(bus.overrun_cnt), 0);
`endif
  endtask

  // A line finishes: accepted if the slot is free after any same-cycle ack, dropped otherwise.
  task automatic model_complete(input bit ack, input bit clr);
    bit dropped;
    if (ack) m_pend = 0;
    m_fd = (m_idx == NL - 1);
    dropped = m_pend;
    if (!dropped) begin
      m_pend = 1; m_lbank = m_bank; m_lnum = m_idx; m_bank = !m_bank;
      if (clr) begin m_ovr = 0; m_cnt = 0; end
    end else begin
      m_ovr = 1;
      if (clr) m_cnt = 1;
      else if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    m_idx = (m_idx + 1) % NL;
  endtask

  task automatic check_line(input string tag);
    chk1({tag, "_line_valid"}, bus.line_valid, m_pend);
    if (m_pend) begin
      chk1({tag, "_line_bank"}, bus.line_bank, m_lbank);
      chkv({tag, "_line_num"}, 32'(bus.line_num), m_lnum);
    end
    chk1({tag, "_overrun"}, bus.overrun, m_ovr);
    chk1({tag, "_frame_done"}, bus.frame_done, m_fd);
    chk1({tag, "_wr_bank"}, bus.wr_bank, m_bank);
`ifdef OVERRUN_COUNT_EN
    chkv({tag, "_overrun_cnt"}, 32'(bus.overrun_cnt), m_cnt);
`endif
  endtask

  task automatic edge_and_gap(input bit ack_gap, input bit clr_gap);
    bus.sweep_trig = 1'b1;
    bus.sample_valid = 1'($urandom % 2);
    tick();
    chk1("edge_no_write", bus.wr_en, 1'b0);
    chk1("frame_done_one_cycle", bus.frame_done, 1'b0);
    bus.sweep_trig = 1'b0;
    bus.sample_valid = 1'b0;
    bus.line_ack = ack_gap;
    bus.overrun_clr = clr_gap;
    tick();
    bus.line_ack = 1'b0;
    bus.overrun_clr = 1'b0;
    if (ack_gap) m_pend = 0;
    if (clr_gap) begin m_ovr = 0; m_cnt = 0; end
    m_fd = 0;
    chk1("gap_line_valid", bus.line_valid, m_pend);
    chk1("gap_overrun", bus.overrun, m_ovr);
  endtask

  task automatic sample(input int k);
    repeat ($urandom % 3) begin
      bus.sample_valid = 1'b0;
      bus.sweep_trig = 1'($urandom % 2);
      tick();
      chk1("idle_wr_en", bus.wr_en, 1'b0);
    end
    bus.sweep_trig = 1'b0;
    bus.sample_valid = 1'b1;
    tick();
    chk1("wr_en", bus.wr_en, 1'b1);
    chkv("wr_addr", 32'(bus.wr_addr), k);
    chk1("wr_bank_during_line", bus.wr_bank, m_bank);
  endtask

  // ack_mode: 0 no ack, 1 ack just after the trigger, 2 ack in the completion cycle
  task automatic run_line(input int ack_mode, input bit clr_done, input bit clr_gap);
    edge_and_gap(ack_mode == 1, clr_gap);
    for (int k = 0; k < NS; k++) sample(k);
    bus.sample_valid = 1'b0;
    bus.line_ack = (ack_mode == 2);
    bus.overrun_clr = clr_done;
    tick();
    bus.line_ack = 1'b0;
    bus.overrun_clr = 1'b0;
    model_complete(ack_mode == 2, clr_done);
    check_line("done");
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sweep_trig = 1'b0;
    bus.sample_valid = 1'b0;
    bus.line_ack = 1'b0;
    bus.overrun_clr = 1'b0;
    model_reset();
    tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    check_zero("post_reset");

    bus.enable = 1'b1;
    tick();
    // first line lands in bank 0, line 0
    run_line(0, 0, 0);
    // readout keeps pace across a frame wrap (NL=3)
    run_line(1, 0, 0);
    run_line(1, 0, 0);
    run_line(1, 0, 0);
    // stall: pending line not consumed, next line is dropped
    run_line(0, 0, 0);
    run_line(1, 0, 0);
    // ack coinciding with completion
    run_line(2, 0, 0);
    // drop coinciding with clear keeps the flag; a later clear drops it
    run_line(0, 1, 0);
    run_line(1, 0, 1);

    // abort after two samples: partial line discarded, index restarts at 0
    edge_and_gap(1'b1, 1'b0);
    sample(0);
    sample(1);
    bus.enable = 1'b0;
    bus.sample_valid = 1'b1;
    tick();
    chk1("abort_no_write", bus.wr_en, 1'b0);
    bus.sample_valid = 1'b0;
    tick();
    tick();
    chk1("abort_no_line", bus.line_valid, 1'b0);
    m_idx = 0;
    bus.enable = 1'b1;
    tick();
    run_line(0, 0, 0);
    chkv("restart_line_num", 32'(bus.line_num), 0);

    // reset in the middle of acquisition
    edge_and_gap(1'b1, 1'b0);
    sample(0);
    bus.sample_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("mid_acq_reset");
    model_reset();
    tick();
    reset_n = 1'b1;
    bus.sample_valid = 1'b0;
    tick();
    check_zero("after_reset_release");
    run_line(1, 0, 0);

    // randomized sweeps
    for (int n = 0; n < 40; n++)
      run_line(int'($urandom % 3), ($urandom % 4) == 0, ($urandom % 4) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
